// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: round-robin arbiter that serialises per-core read/write requests
// onto a single shared 8-bit data memory port and returns a one-cycle acq pulse.
module dmem_arbiter #(
  parameter int N_CORES = 4,
  parameter int MEM_LAT = 1,
  parameter int IDW     = 2
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [N_CORES-1:0]     rd_req,
  input  logic [N_CORES-1:0]     wr_req,
  input  logic [8*N_CORES-1:0]   addr_in,
  input  logic [8*N_CORES-1:0]   wdata_in,
  output logic [N_CORES-1:0]     acq,
  output logic [7:0]             rdata,
  output logic [7:0]             mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_re,
  output logic                   mem_we,
  input  logic [7:0]             mem_rdata,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam int         CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [N_CORES-1:0] ack_mask_q, ack_mask_d;
  logic [N_CORES-1:0] acq_q, acq_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               op_wr_q, op_wr_d;
  logic               mem_re_q, mem_re_d;
  logic               mem_we_q, mem_we_d;
  logic               busy_w;

  logic [N_CORES-1:0] req_w;
  logic [N_CORES-1:0] req_rot_w;
  logic               pick_vld_w;
  logic [IDW-1:0]     pick_id_w;
  logic [7:0]         pick_addr_w;
  logic [7:0]         pick_wdata_w;
  logic               pick_wr_w;
  logic [N_CORES-1:0] grant_oh_w;
  logic [IDW-1:0]     next_ptr_w;

  // The mask suppresses the core just served for the single IDLE cycle
  // in which it is still dropping its request.
  assign req_w      = (rd_req | wr_req) & ~ack_mask_q;
  assign req_rot_w  = N_CORES'({req_w, req_w} >> rr_ptr_q);
  assign grant_oh_w = N_CORES'(1) << grant_id_q;
  assign next_ptr_w = (grant_id_q == IDW'(N_CORES - 1)) ? '0 : grant_id_q + IDW'(1);

  // Descending scan so the lowest rotated index (closest to rr_ptr) wins.
  always_comb begin
    pick_vld_w = 1'b0;
    pick_id_w  = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (req_rot_w[i]) begin
        pick_vld_w = 1'b1;
        pick_id_w  = IDW'((int'(rr_ptr_q) + i) % N_CORES);
      end
    end
  end

  always_comb begin
    pick_addr_w  = '0;
    pick_wdata_w = '0;
    pick_wr_w    = 1'b0;
    for (int k = 0; k < N_CORES; k++) begin
      if (pick_id_w == IDW'(k)) begin
        pick_addr_w  = addr_in[8*k +: 8];
        pick_wdata_w = wdata_in[8*k +: 8];
        pick_wr_w    = wr_req[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld_w) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (MEM_LAT == 0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CW'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_w = (state_q != S_IDLE);
  end

  always_comb begin
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    ack_mask_d = ack_mask_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_wr_d    = op_wr_q;
    rdata_d    = rdata_q;
    mem_re_d   = 1'b0;
    mem_we_d   = 1'b0;
    acq_d      = '0;

    if (state_q == S_IDLE) begin
      ack_mask_d = '0;
      if (pick_vld_w) begin
        grant_id_d = pick_id_w;
        addr_d     = pick_addr_w;
        wdata_d    = pick_wdata_w;
        op_wr_d    = pick_wr_w;
        mem_we_d   = pick_wr_w;
        mem_re_d   = ~pick_wr_w;
      end
    end

    if (state_q == S_DONE) begin
      rr_ptr_d   = next_ptr_w;
      ack_mask_d = grant_oh_w;
    end

    // DONE is only ever entered from ACCESS or WAIT, so this marks its entry edge.
    if (state_d == S_DONE && state_q != S_DONE) begin
      acq_d = grant_oh_w;
      if (!op_wr_q) rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      ack_mask_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_wr_q    <= 1'b0;
      rdata_q    <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      acq_q      <= '0;
    end else begin
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_mask_q <= ack_mask_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_wr_q    <= op_wr_d;
      rdata_q    <= rdata_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      acq_q      <= acq_d;
    end
  end

  assign acq       = acq_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_w;
  assign grant_id  = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// synchronous one-cycle-latency RAM model.
module tb_dmem_arbiter;

  localparam int N   = 4;
  localparam int LAT = 1;
  localparam int IDW = 2;

  logic           CLK  = 1'b0;
  logic           RSTn = 1'b0;
  logic [N-1:0]   rd_req, wr_req, acq;
  logic [8*N-1:0] addr_in, wdata_in;
  logic [7:0]     rdata, mem_addr, mem_wdata;
  logic [7:0]     mem_rdata = 8'h00;
  logic           mem_re, mem_we, busy;
  logic [IDW-1:0] grant_id;
  logic           preload;
  logic [7:0]     ram [256];

  int n_chk  = 0;
  int n_pass = 0;

  dmem_arbiter #(.N_CORES(N), .MEM_LAT(LAT), .IDW(IDW)) u_dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .acq       (acq),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (preload)     ram[8'h3C] <= 8'hA5;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Bounded wait for any acq; a timeout returns a=0 so the caller's check fails.
  task automatic wait_acq(output logic [N-1:0] a, output int cyc);
    a   = '0;
    cyc = 0;
    while (a == '0 && cyc < 20) begin
      @(negedge CLK);
      cyc++;
      a = acq;
    end
  endtask

  initial begin
    logic [N-1:0] a;
    int           cyc;
    int           exp_id;

    rd_req   = '1;
    wr_req   = '0;
    addr_in  = '0;
    wdata_in = '0;
    preload  = 1'b1;

    // Reset held with every core requesting
    repeat (3) @(negedge CLK);
    check("rst_acq",    acq,      0);
    check("rst_mem_re", mem_re,   0);
    check("rst_mem_we", mem_we,   0);
    check("rst_busy",   busy,     0);
    check("rst_gid",    grant_id, 0);
    check("rst_rdata",  rdata,    0);
    check("rst_maddr",  mem_addr, 0);
    preload = 1'b0;

    // Round robin: all cores keep requesting, expect 0,1,2,3,0
    RSTn = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_id = g % N;
      wait_acq(a, cyc);
      check("rr_acq",  a,        32'd1 << exp_id);
      check("rr_lat",  cyc,      3);
      check("rr_gid",  grant_id, exp_id);
      check("rr_busy", busy,     1);
      rd_req[exp_id] = 1'b0;
      @(negedge CLK);
      check("rr_pulse", acq, 0);
      if (g < 4) rd_req[exp_id] = 1'b1;
    end
    rd_req = '0;
    repeat (2) @(negedge CLK);
    check("rr_idle", busy, 0);

    // Single read of 0x3C by core0
    addr_in[7:0] = 8'h3C;
    rd_req       = 4'b0001;
    @(negedge CLK);
    check("rd_re",    mem_re,   1);
    check("rd_we",    mem_we,   0);
    check("rd_addr",  mem_addr, 8'h3C);
    check("rd_busy",  busy,     1);
    @(negedge CLK);
    check("rd_re_off", mem_re, 0);
    check("rd_early",  acq,    0);
    @(negedge CLK);
    check("rd_acq",   acq,   4'b0001);
    check("rd_rdata", rdata, 8'hA5);
    rd_req = '0;
    @(negedge CLK);
    check("rd_acq_off", acq, 0);

    // Write 0x7E to 0x10 by core2; its inputs change after the grant
    addr_in[23:16]  = 8'h10;
    wdata_in[23:16] = 8'h7E;
    wr_req          = 4'b0100;
    @(negedge CLK);
    check("wr_we",    mem_we,    1);
    check("wr_re",    mem_re,    0);
    check("wr_addr",  mem_addr,  8'h10);
    check("wr_wdata", mem_wdata, 8'h7E);
    addr_in[23:16]  = 8'h55;
    wdata_in[23:16] = 8'h00;
    @(negedge CLK);
    check("wr_we_off",  mem_we,   0);
    check("wr_addr_hold", mem_addr, 8'h10);
    @(negedge CLK);
    check("wr_acq", acq,      4'b0100);
    check("wr_gid", grant_id, 2);
    wr_req = '0;
    @(negedge CLK);
    check("wr_acq_off", acq, 0);

    // Read back 0x10 by core1
    addr_in[15:8] = 8'h10;
    rd_req        = 4'b0010;
    @(negedge CLK);
    check("rb_re",   mem_re,   1);
    check("rb_addr", mem_addr, 8'h10);
    @(negedge CLK);
    @(negedge CLK);
    check("rb_acq",   acq,   4'b0010);
    check("rb_rdata", rdata, 8'h7E);
    rd_req = '0;
    @(negedge CLK);

    // Abort core2 read during WAIT; pointer is 2 at this point
    addr_in[23:16] = 8'h3C;
    rd_req         = 4'b0100;
    @(negedge CLK);
    check("ab_access", busy, 1);
    @(negedge CLK);
    check("ab_wait_busy", busy, 1);
    check("ab_wait_acq",  acq,  0);
    RSTn   = 1'b0;
    rd_req = '0;
    #1;
    check("ab_busy",  busy,     0);
    check("ab_acq",   acq,      0);
    check("ab_gid",   grant_id, 0);
    check("ab_maddr", mem_addr, 0);
    @(negedge CLK);
    @(negedge CLK);
    check("ab_no_acq", acq, 0);

    // Re-request after reset: cores 1 and 3; pointer restarted at 0 -> core1
    RSTn   = 1'b1;
    rd_req = 4'b1010;
    wait_acq(a, cyc);
    check("rq_acq",   a,        4'b0010);
    check("rq_lat",   cyc,      3);
    check("rq_rdata", rdata,    8'h7E);
    rd_req = '0;
    @(negedge CLK);
    check("rq_acq_off", acq, 0);
    @(negedge CLK);
    check("rq_drop_idle", busy, 0);

    // Core3 asserts read and write together: the write wins
    addr_in[31:24]  = 8'h20;
    wdata_in[31:24] = 8'h99;
    rd_req          = 4'b1000;
    wr_req          = 4'b1000;
    @(negedge CLK);
    check("rw_we", mem_we, 1);
    check("rw_re", mem_re, 0);
    @(negedge CLK);
    @(negedge CLK);
    check("rw_acq",   acq,   4'b1000);
    check("rw_rdata", rdata, 8'h7E);
    rd_req = '0;
    wr_req = '0;
    @(negedge CLK);
    check("rw_acq_off", acq, 0);
    @(negedge CLK);
    check("rw_idle", busy, 0);
    check("rw_ram",  ram[8'h20], 8'h99);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
